// File: rtl/ntt_bram_arbiter_pkg.sv
// Shared types and constants for the NTT coefficient BRAM arbiter.
package ntt_bram_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    localparam int REQ_LOAD = 0;
    localparam int REQ_NTT  = 1;
    localparam int REQ_RED  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } arb_state_t;

    // One slot of the read-return tag pipe.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/ntt_bram_arbiter_if.sv
// Requester bus plus BRAM-side port, shared by the arbiter and its users.
interface ntt_bram_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        r_wen;
    logic [N_REQ*ADDR_W-1:0] r_wad;
    logic [N_REQ*DATA_W-1:0] r_wdata;
    logic [N_REQ-1:0]        r_ren;
    logic [N_REQ*ADDR_W-1:0] r_rad;
    logic [N_REQ-1:0]        rvalid;
    logic                    m_wen;
    logic [ADDR_W-1:0]       m_wad;
    logic [DATA_W-1:0]       m_wdata;
    logic [ADDR_W-1:0]       m_rad;
    logic [DATA_W-1:0]       m_rdata;

    // Arbiter side; m_rdata bypasses the arbiter and goes straight to requesters.
    modport slave (
        input  req, r_wen, r_wad, r_wdata, r_ren, r_rad,
        output gnt, rvalid, m_wen, m_wad, m_wdata, m_rad
    );

    // Requesters plus the BRAM itself.
    modport master (
        output req, r_wen, r_wad, r_wdata, r_ren, r_rad, m_rdata,
        input  gnt, rvalid, m_wen, m_wad, m_wdata, m_rad
    );
endinterface

// File: rtl/ntt_bram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr.
module ntt_rr_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       rr_ptr,
    output logic [1:0]       win,
    output logic             any
);
    // Scan rr_ptr, rr_ptr+1, ... modulo N_REQ and keep the first hit.
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                win   = idx[1:0];
                found = 1'b1;
            end
        end
        any = |req;
    end
endmodule

// File: rtl/ntt_bram_arbiter.sv
// Round-robin owner arbiter for the shared NTT coefficient BRAM.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | no owner; arbitrate among pending requesters
//  S_GRANT | owner's port forwarded to BRAM until it drops req
//  S_DRAIN | nothing forwarded; RD_LAT cycles so owner's reads return
module ntt_bram_arbiter
    import ntt_bram_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ntt_bram_arbiter_if.slave   bus,
    output logic                busy,
    output logic [1:0]          owner,
    output logic                proto_err
);
    arb_state_t        state;
    logic [N_REQ-1:0]  gnt;
    logic [1:0]        rr_ptr;
    logic [1:0]        drain_cnt;
    logic [1:0]        win;
    logic              any;
    logic              active;
    logic              rd_acc;
    logic              m_wen;
    logic [ADDR_W-1:0] m_wad;
    logic [DATA_W-1:0] m_wdata;
    logic [ADDR_W-1:0] m_rad;
    logic [N_REQ-1:0]  rvalid;
    rd_tag_t           tag_pipe [RD_LAT];

    ntt_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .win    (win),
        .any    (any)
    );

    // Ownership FSM; DRAIN length is a down-counter ending at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gnt       <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any) begin
                        gnt    <= N_REQ'(1) << win;
                        owner  <= win;
                        rr_ptr <= (win == 2'(N_REQ-1)) ? 2'd0 : win + 2'd1;
                        state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!bus.req[owner]) begin
                        gnt       <= '0;
                        drain_cnt <= 2'(RD_LAT-1);
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd0) state <= S_IDLE;
                    else                   drain_cnt <= drain_cnt - 2'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign active = (state == S_GRANT) && gnt[owner];
    assign busy   = (state != S_IDLE);

    // Forward only the owner's port; everything else reads as zero.
    always_comb begin
        m_wen   = 1'b0;
        m_wad   = '0;
        m_wdata = '0;
        m_rad   = '0;
        rd_acc  = 1'b0;
        if (active) begin
            m_wen   = bus.r_wen[owner];
            m_wad   = bus.r_wad[owner*ADDR_W +: ADDR_W];
            m_wdata = bus.r_wdata[owner*DATA_W +: DATA_W];
            m_rad   = bus.r_rad[owner*ADDR_W +: ADDR_W];
            rd_acc  = bus.r_ren[owner];
        end
    end

    // Tag pipe matching the BRAM read latency; cleared on reset so no stale rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: rd_acc, idx: owner};
            for (int k = 1; k < RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    // Decode the oldest tag into a one-hot return strobe.
    always_comb begin
        rvalid = '0;
        if (tag_pipe[RD_LAT-1].valid) rvalid[tag_pipe[RD_LAT-1].idx] = 1'b1;
    end

    // Sticky flag for any strobe raised by a requester that does not hold the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    proto_err <= 1'b0;
        else if (|((bus.r_wen | bus.r_ren) & ~gnt))    proto_err <= 1'b1;
    end

    assign bus.gnt     = gnt;
    assign bus.rvalid  = rvalid;
    assign bus.m_wen   = m_wen;
    assign bus.m_wad   = m_wad;
    assign bus.m_wdata = m_wdata;
    assign bus.m_rad   = m_rad;
endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// Directed bench: RD_LAT=1 instance for most scenarios, RD_LAT=3 instance for latency cases.
module tb_ntt_bram_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic busy1, busy3, perr1, perr3;
    logic [1:0] owner1, owner3;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ntt_bram_arbiter_if #(.N_REQ(3), .ADDR_W(8), .DATA_W(16)) bus1 ();
    ntt_bram_arbiter_if #(.N_REQ(3), .ADDR_W(8), .DATA_W(16)) bus3 ();

    ntt_bram_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(16), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .owner(owner1), .proto_err(perr1));
    ntt_bram_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(16), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3), .owner(owner3), .proto_err(perr3));

    // BRAM models: write port A, read port B with 1 and 3 cycle latency
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] p3a, p3b;
    always @(posedge clk) begin
        if (bus1.m_wen) mem1[bus1.m_wad] <= bus1.m_wdata;
        bus1.m_rdata <= mem1[bus1.m_rad];
        if (bus3.m_wen) mem3[bus3.m_wad] <= bus3.m_wdata;
        p3a <= mem3[bus3.m_rad];
        p3b <= p3a;
        bus3.m_rdata <= p3b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus1.req = '0; bus1.r_wen = '0; bus1.r_wad = '0; bus1.r_wdata = '0;
        bus1.r_ren = '0; bus1.r_rad = '0;
        bus3.req = '0; bus3.r_wen = '0; bus3.r_wad = '0; bus3.r_wdata = '0;
        bus3.r_ren = '0; bus3.r_rad = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle1(input string name);
        int n = 0;
        while (busy1 && n < 20) begin tick(); n++; end
        tests++;
        if (busy1 !== 1'b0) begin
            fails++;
            $display("FAIL %s: busy=%b required 0 within 20 cycles", name, busy1);
        end
    endtask

    task automatic test_reset();
        logic seen;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++;
        if ({bus1.gnt, bus1.rvalid, busy1, owner1, perr1, bus1.m_wen, bus1.m_wad,
             bus1.m_wdata, bus1.m_rad} !== '0) begin
            fails++;
            $display("FAIL reset_values: gnt=%b rvalid=%b busy=%b owner=%0d perr=%b m_wen=%b m_wad=%h m_wdata=%h m_rad=%h required all 0",
                     bus1.gnt, bus1.rvalid, busy1, owner1, perr1, bus1.m_wen, bus1.m_wad, bus1.m_wdata, bus1.m_rad);
        end
        rst_n = 1'b1;
        tick();
        bus3.req = 3'b001;
        tick();
        tests++;
        if (bus3.gnt !== 3'b001) begin
            fails++;
            $display("FAIL reset_pre_grant: gnt=%b required 001", bus3.gnt);
        end
        bus3.r_ren = 3'b001;
        bus3.r_rad[7:0] = 8'h10;
        tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus3.gnt, busy3, bus3.rvalid, bus3.m_rad, owner3} !== '0) begin
            fails++;
            $display("FAIL reset_async: gnt=%b busy=%b rvalid=%b m_rad=%h owner=%0d required all 0",
                     bus3.gnt, busy3, bus3.rvalid, bus3.m_rad, owner3);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (bus3.rvalid !== 3'b000) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_rvalid: rvalid seen=%b required 0", seen);
        end
    endtask

    task automatic test_single_owner();
        bus1.req = 3'b010;
        tick();
        tests++;
        if (bus1.gnt !== 3'b010 || owner1 !== 2'd1 || busy1 !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: gnt=%b owner=%0d busy=%b required 010/1/1", bus1.gnt, owner1, busy1);
        end
        bus1.r_wen = 3'b010;
        bus1.r_wad[8 +: 8] = 8'h05;
        bus1.r_wdata[16 +: 16] = 16'h0ABC;
        #1;
        tests++;
        if (bus1.m_wen !== 1'b1 || bus1.m_wad !== 8'h05 || bus1.m_wdata !== 16'h0ABC) begin
            fails++;
            $display("FAIL single_write_fwd: m_wen=%b m_wad=%h m_wdata=%h required 1/05/0abc",
                     bus1.m_wen, bus1.m_wad, bus1.m_wdata);
        end
        tick();
        bus1.r_wen = 3'b000;
        bus1.r_ren = 3'b010;
        bus1.r_rad[8 +: 8] = 8'h05;
        #1;
        tests++;
        if (bus1.m_rad !== 8'h05 || bus1.rvalid !== 3'b000) begin
            fails++;
            $display("FAIL single_read_fwd: m_rad=%h rvalid=%b required 05/000", bus1.m_rad, bus1.rvalid);
        end
        tick();
        bus1.r_ren = 3'b000;
        tests++;
        if (bus1.rvalid !== 3'b010 || bus1.m_rdata !== 16'h0ABC) begin
            fails++;
            $display("FAIL single_read_data: rvalid=%b m_rdata=%h required 010/0abc", bus1.rvalid, bus1.m_rdata);
        end
        tick();
        tests++;
        if (bus1.rvalid !== 3'b000) begin
            fails++;
            $display("FAIL single_rvalid_once: rvalid=%b required 000", bus1.rvalid);
        end
        bus1.req = 3'b000;
        tick();
        tests++;
        if (bus1.gnt !== 3'b000 || busy1 !== 1'b1) begin
            fails++;
            $display("FAIL single_drain: gnt=%b busy=%b required 000/1", bus1.gnt, busy1);
        end
        tick();
        tests++;
        if (busy1 !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: busy=%b required 0", busy1);
        end
    endtask

    task automatic test_contention();
        int gap;
        do_reset();
        bus1.req = 3'b111;
        tick();
        tests++;
        if (bus1.gnt !== 3'b001) begin
            fails++;
            $display("FAIL cont_first: gnt=%b required 001", bus1.gnt);
        end
        tick();
        tests++;
        if (bus1.gnt !== 3'b001) begin
            fails++;
            $display("FAIL cont_hold: gnt=%b required 001", bus1.gnt);
        end
        for (int w = 1; w < 3; w++) begin
            bus1.req[w-1] = 1'b0;
            tick();
            gap = 1;
            while (bus1.gnt === 3'b000 && gap < 10) begin
                tick();
                if (bus1.gnt === 3'b000) gap++;
            end
            tests++;
            if (bus1.gnt !== 3'(3'b001 << w) || owner1 !== 2'(w)) begin
                fails++;
                $display("FAIL cont_order_%0d: gnt=%b owner=%0d required %b/%0d",
                         w, bus1.gnt, owner1, 3'(3'b001 << w), w);
            end
            tests++;
            if (gap !== 2) begin
                fails++;
                $display("FAIL cont_gap_%0d: gap=%0d required 2", w, gap);
            end
        end
        bus1.req = 3'b000;
        wait_idle1("cont_release");
    endtask

    task automatic test_release_read();
        bus1.req = 3'b001;
        tick();
        tests++;
        if (bus1.gnt !== 3'b001) begin
            fails++;
            $display("FAIL rel_grant: gnt=%b required 001", bus1.gnt);
        end
        bus1.req = 3'b010;
        bus1.r_ren = 3'b001;
        bus1.r_rad[7:0] = 8'h05;
        #1;
        tests++;
        if (bus1.m_rad !== 8'h05) begin
            fails++;
            $display("FAIL rel_last_fwd: m_rad=%h required 05", bus1.m_rad);
        end
        tick();
        bus1.r_ren = 3'b000;
        tests++;
        if (bus1.gnt !== 3'b000 || bus1.rvalid !== 3'b001 || bus1.m_rdata !== 16'h0ABC) begin
            fails++;
            $display("FAIL rel_drain_rvalid: gnt=%b rvalid=%b m_rdata=%h required 000/001/0abc",
                     bus1.gnt, bus1.rvalid, bus1.m_rdata);
        end
        tick();
        tests++;
        if (bus1.gnt !== 3'b000 || bus1.rvalid !== 3'b000) begin
            fails++;
            $display("FAIL rel_arb_cycle: gnt=%b rvalid=%b required 000/000", bus1.gnt, bus1.rvalid);
        end
        tick();
        tests++;
        if (bus1.gnt !== 3'b010 || perr1 !== 1'b0) begin
            fails++;
            $display("FAIL rel_next_owner: gnt=%b perr=%b required 010/0", bus1.gnt, perr1);
        end
        bus1.req = 3'b000;
        wait_idle1("rel_release");
    endtask

    task automatic test_violation();
        bus1.req = 3'b001;
        tick();
        tests++;
        if (bus1.gnt !== 3'b001) begin
            fails++;
            $display("FAIL viol_grant: gnt=%b required 001", bus1.gnt);
        end
        bus1.r_wen = 3'b100;
        bus1.r_wad[16 +: 8] = 8'h05;
        bus1.r_wdata[32 +: 16] = 16'hDEAD;
        #1;
        tests++;
        if (bus1.m_wen !== 1'b0) begin
            fails++;
            $display("FAIL viol_m_wen: m_wen=%b required 0", bus1.m_wen);
        end
        tick();
        bus1.r_wen = 3'b000;
        tests++;
        if (perr1 !== 1'b1) begin
            fails++;
            $display("FAIL viol_flag: proto_err=%b required 1", perr1);
        end
        bus1.r_ren = 3'b001;
        bus1.r_rad[7:0] = 8'h05;
        tick();
        bus1.r_ren = 3'b000;
        tests++;
        if (bus1.rvalid !== 3'b001 || bus1.m_rdata !== 16'h0ABC) begin
            fails++;
            $display("FAIL viol_bram_intact: rvalid=%b m_rdata=%h required 001/0abc", bus1.rvalid, bus1.m_rdata);
        end
        bus1.req = 3'b000;
        wait_idle1("viol_release");
        tick();
        tests++;
        if (perr1 !== 1'b1) begin
            fails++;
            $display("FAIL viol_sticky: proto_err=%b required 1", perr1);
        end
    endtask

    task automatic test_lat3();
        int drain;
        logic [2:0]  exp_v;
        do_reset();
        tests++;
        if (perr1 !== 1'b0) begin
            fails++;
            $display("FAIL perr_cleared: proto_err=%b required 0", perr1);
        end
        bus3.req = 3'b100;
        tick();
        tests++;
        if (bus3.gnt !== 3'b100 || owner3 !== 2'd2) begin
            fails++;
            $display("FAIL lat3_grant: gnt=%b owner=%0d required 100/2", bus3.gnt, owner3);
        end
        for (int k = 0; k < 4; k++) begin
            bus3.r_wen = 3'b100;
            bus3.r_wad[16 +: 8] = 8'(8'h20 + k);
            bus3.r_wdata[32 +: 16] = 16'(16'h1000 + k);
            tick();
        end
        bus3.r_wen = 3'b000;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) begin
                bus3.r_ren = 3'b100;
                bus3.r_rad[16 +: 8] = 8'(8'h20 + j);
            end else begin
                bus3.r_ren = 3'b000;
            end
            tick();
            exp_v = (j >= 2 && j <= 5) ? 3'b100 : 3'b000;
            tests++;
            if (bus3.rvalid !== exp_v) begin
                fails++;
                $display("FAIL lat3_rvalid_%0d: rvalid=%b required %b", j, bus3.rvalid, exp_v);
            end
            if (j >= 2 && j <= 5) begin
                tests++;
                if (bus3.m_rdata !== 16'(16'h1000 + j - 2)) begin
                    fails++;
                    $display("FAIL lat3_data_%0d: m_rdata=%h required %h", j, bus3.m_rdata, 16'(16'h1000 + j - 2));
                end
            end
        end
        bus3.req = 3'b000;
        tick();
        tests++;
        if (bus3.gnt !== 3'b000) begin
            fails++;
            $display("FAIL lat3_release: gnt=%b required 000", bus3.gnt);
        end
        drain = 0;
        while (busy3 && drain < 10) begin
            drain++;
            tick();
        end
        tests++;
        if (drain !== 3 || perr3 !== 1'b0) begin
            fails++;
            $display("FAIL lat3_drain_len: drain=%0d proto_err=%b required 3/0", drain, perr3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_owner();
        test_contention();
        test_release_read();
        test_violation();
        test_lat3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
